// File: rtl/lcd_scan_out.sv
// Raster scan-out for a 480x272 RGB LCD: timing generation, framebuffer
// addressing and 8x8 pixel expansion of 4-bit IRGB indices into RGB565.
module lcd_scan_out #(
  parameter int H_ACTIVE    = 480,
  parameter int H_FRONT     = 8,
  parameter int H_SYNC      = 4,
  parameter int H_BACK      = 43,
  parameter int V_ACTIVE    = 272,
  parameter int V_FRONT     = 8,
  parameter int V_SYNC      = 4,
  parameter int V_BACK      = 12,
  parameter int SCALE_SHIFT = 3,
  parameter int FB_W        = 60,
  parameter int FB_H        = 32
) (
  input  logic       clk,
  input  logic       rst,
  output logic [5:0] x_output,
  output logic [5:0] y_output,
  input  logic [3:0] frame,
  output logic       lcd_de,
  output logic       lcd_hsync,
  output logic       lcd_vsync,
  output logic [4:0] lcd_r,
  output logic [5:0] lcd_g,
  output logic [4:0] lcd_b,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_DE_END   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] H_IMG_END  = HW'(FB_W << SCALE_SHIFT);

  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_DE_END   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] V_IMG_END  = VW'(FB_H << SCALE_SHIFT);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          in_image;
  logic [4:0]    pal_r;
  logic [5:0]    pal_g;
  logic [4:0]    pal_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // The image area is smaller than the panel; the remainder is a black border.
  assign in_image = (h_cnt < H_IMG_END) && (v_cnt < V_IMG_END);
  assign x_output = in_image ? 6'(h_cnt >> SCALE_SHIFT) : 6'd0;
  assign y_output = in_image ? 6'(v_cnt >> SCALE_SHIFT) : 6'd0;

  // IRGB palette; the lone intensity bit with no colour is a dim grey.
  always_comb begin
    pal_r = 5'd0;
    pal_g = 6'd0;
    pal_b = 5'd0;
    if (frame == 4'b1000) begin
      pal_r = 5'd8;
      pal_g = 6'd16;
      pal_b = 5'd8;
    end else begin
      if (frame[2]) pal_r = frame[3] ? 5'd31 : 5'd20;
      if (frame[1]) pal_g = frame[3] ? 6'd63 : 6'd40;
      if (frame[0]) pal_b = frame[3] ? 5'd31 : 5'd20;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lcd_de      <= 1'b0;
      lcd_hsync   <= 1'b1;
      lcd_vsync   <= 1'b1;
      lcd_r       <= 5'd0;
      lcd_g       <= 6'd0;
      lcd_b       <= 5'd0;
      frame_start <= 1'b0;
    end else begin
      lcd_de      <= (h_cnt < H_DE_END) && (v_cnt < V_DE_END);
      lcd_hsync   <= !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
      lcd_vsync   <= !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
      lcd_r       <= in_image ? pal_r : 5'd0;
      lcd_g       <= in_image ? pal_g : 6'd0;
      lcd_b       <= in_image ? pal_b : 5'd0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: doc/lcd_scan_out.md
Name: lcd_scan_out

Overview:
- Downstream consumer of the 60x32x4-bit framebuffer.
- Generates RGB-LCD raster timing (DE, HSYNC, VSYNC) for the 480x272 panel.
- Drives the framebuffer read address and expands each 4-bit pixel index 8x8 into RGB565.
- Emits a one-cycle frame_start pulse that the CPU side uses as a vsync tick.

Parameters:
H_ACTIVE, 480, visible pixels per line
H_FRONT, 8, horizontal front porch (pixel clocks)
H_SYNC, 4, HSYNC low width (pixel clocks)
H_BACK, 43, horizontal back porch
V_ACTIVE, 272, visible lines per frame
V_FRONT, 8, vertical front porch (lines)
V_SYNC, 4, VSYNC low width (lines)
V_BACK, 12, vertical back porch
SCALE_SHIFT, 3, log2 of pixel replication factor (8x8 per framebuffer cell)
FB_W, 60, framebuffer columns; FB_W<<SCALE_SHIFT must be <= H_ACTIVE
FB_H, 32, framebuffer rows; FB_H<<SCALE_SHIFT must be <= V_ACTIVE

Ports:
clk  input  1  pixel clock
rst  input  1  synchronous, active-high reset
x_output  output  6  framebuffer column address
y_output  output  6  framebuffer row address
frame  input  4  pixel index returned combinationally for (x_output, y_output)
lcd_de  output  1  data enable
lcd_hsync  output  1  horizontal sync, active low
lcd_vsync  output  1  vertical sync, active low
lcd_r  output  5  red
lcd_g  output  6  green
lcd_b  output  5  blue
frame_start  output  1  one-cycle pulse at start of each frame

Behaviour:
- Interface (already decided): one clock, clk; rst is synchronous, active-high.
- Counters:
  - h_cnt runs 0..H_TOTAL-1, with H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK = 535.
  - v_cnt runs 0..V_TOTAL-1, with V_TOTAL = 296.
  - v_cnt increments when h_cnt wraps from H_TOTAL-1 to 0; v_cnt wraps to 0 after V_TOTAL-1.
  - Counter widths are sized to hold H_TOTAL-1 and V_TOTAL-1.
- Region order per line and per frame: active, front porch, sync, back porch.
- Address (combinational from counters):
  - Inside the image region (h_cnt < FB_W<<SCALE_SHIFT and v_cnt < FB_H<<SCALE_SHIFT): x_output = h_cnt>>SCALE_SHIFT, y_output = v_cnt>>SCALE_SHIFT.
  - Outside it, both are 0.
  - x_output never exceeds 59 and y_output never exceeds 31.
- Output stage (all registered; one-cycle latency from counter state to pins):
  - lcd_de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - lcd_hsync = 0 iff H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC (h_cnt 488..491).
  - lcd_vsync = 0 iff V_ACTIVE+V_FRONT <= v_cnt < V_ACTIVE+V_FRONT+V_SYNC (lines 280..283, whole lines).
  - Colour: inside the image region, use the palette of frame; otherwise R=G=B=0. Border lines 256..271 and columns >= 480 are black, but lcd_de stays high on the border lines.
  - frame_start = 1 for the single cycle following h_cnt=0, v_cnt=0.
- Palette (IRGB: bit3 I, bit2 R, bit1 G, bit0 B):
  - A channel whose bit is set gets full (R/B 31, G 63) if I=1, else half (R/B 20, G 40).
  - A channel whose bit is clear gets 0.
  - Index 4'b1000 is grey: R=8, G=16, B=8.
- Reset:
  - h_cnt=0, v_cnt=0.
  - lcd_de=0, lcd_hsync=1, lcd_vsync=1, lcd_r/g/b=0, frame_start=0; x_output=0, y_output=0.
  - Reset asserted mid-frame restarts the raster at (0,0) on the next cycle.
  - First frame_start occurs one cycle after counters first sit at (0,0) with rst low, i.e. in the second cycle after rst falls.
- The block never writes the framebuffer. Framebuffer writes landing mid-frame become visible when that cell is next scanned; no tearing protection.

Test Plan:
- Reset, then count cycles -> frame_start pulses exactly every 535*296 = 158360 cycles, 1 cycle wide; lcd_hsync/lcd_vsync idle high and lcd_de=0 while rst=1.
- Observe one line -> lcd_de high for exactly 480 consecutive cycles per active line; lcd_hsync low exactly 4 cycles, starting 488 cycles after DE rises; line period 535.
- Observe one frame -> lcd_vsync low for 4*535 = 2140 cycles beginning at line 280; lcd_de never high on lines 272..295.
- Framebuffer model with cell (10,5)=4'b1100 and all other cells 0 -> R=31, G=0, B=0 exactly at h=80..87 on lines 40..47; every other active pixel is black; x_output=10 and y_output=5 while h_cnt is in 80..87.
- All cells = 4'b0111 -> active pixels R=20, G=40, B=20 on lines 0..255; lines 256..271 black with lcd_de=1; columns >= 480 are never enabled.
- Assert rst for 1 cycle at h_cnt=300, v_cnt=100 -> next cycle counters are (0,0) and outputs hold reset values; frame_start pulses one cycle later; full timing resumes correctly.
